fp32_add_arbiter: RTL and testbench
===================================

FP32_ADD_ARBITER -- requirements
Module: fp32_add_arbiter

Interface
REQ-001 Parameter LAT, default 1: cycles from adder operand presentation to valid adder result; legal range 1..8.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  port 0 has an operand pair.
REQ-005 req0_ready  output  1  port 0 granted this cycle.
REQ-006 req0_a, req0_b  input  32 each  port 0 IEEE-754 binary32 operands.
REQ-007 req1_valid, req1_ready, req1_a, req1_b: same as port 0, for port 1.
REQ-008 rsp0_valid  output  1  port 0 result strobe, one cycle.
REQ-009 rsp0_data  output  32  port 0 sum.
REQ-010 rsp1_valid, rsp1_data: same as port 0, for port 1.
REQ-011 add_a, add_b  output  32 each  operands to the shared float32 adder.
REQ-012 add_res  input  32  adder result, valid LAT cycles after operands.
REQ-013 busy  output  1  high while any operation is in flight.
REQ-014 inflight  output  4  count of in-flight operations, 0..LAT.

Function
REQ-015 The block SHALL transfer a request when reqN_valid and reqN_ready are both high on a rising edge; at most one transfer per cycle.
REQ-016 reqN_ready SHALL be combinational: the grant signal, independent of LAT occupancy, since the adder is fully pipelined.
REQ-017 Only one valid requester: that port SHALL be granted.
REQ-018 Both valid: the port not granted most recently SHALL be granted (round-robin); pointer updates only on a transfer.
REQ-019 Neither valid: no grant, pointer unchanged.
REQ-020 add_a/add_b SHALL be the granted port's operands combinationally in the grant cycle, otherwise 32'h0.
REQ-021 A LAT-deep shift register SHALL carry {valid, port_id} per issue slot, advancing every cycle.
REQ-022 When the shift register output slot is valid with id N, rspN_valid SHALL be high for exactly that cycle with rspN_data = add_res; the other port's rsp_valid SHALL be low.
REQ-023 rspN_data SHALL be 32'h0 whenever rspN_valid is low.
REQ-024 Responses SHALL have no backpressure; results are delivered in issue order, exactly LAT cycles after the transfer edge.
REQ-025 inflight SHALL increment on transfer, decrement on response, stay unchanged on simultaneous transfer and response; never exceeds LAT.
REQ-026 busy SHALL equal (inflight != 0).
REQ-027 A requester deasserting valid without a transfer SHALL cause no issue and no pointer change.
REQ-028 NaN, infinity and denormal operands SHALL pass through untouched; the block never inspects operand values.

Reset
REQ-029 On rst_n low, asynchronously: shift register cleared, inflight = 0, busy = 0, rsp0_valid = rsp1_valid = 0, rsp data = 0, pointer set so port 0 wins the first contention.
REQ-030 While rst_n is low, req0_ready = req1_ready = 0 and add_a = add_b = 0.
REQ-031 Operations in flight at reset SHALL be discarded; no response is produced for them after reset release.
REQ-032 First grant is allowed on the first rising edge with rst_n high.

Verification
REQ-033 LAT=1, only port 0 valid, a=32'h3F800000 (1.0), b=32'h40000000 (2.0) -> req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_data=32'h40400000; rsp1_valid=0.
REQ-034 Both ports valid continuously after reset for 4 cycles -> grants 0,1,0,1; responses alternate rsp0/rsp1, one per cycle, LAT cycles later.
REQ-035 LAT=3, port 1 issues 0.5+1.0 (32'h3F000000, 32'h3F800000) back-to-back 3 times -> inflight reaches 3, rsp1_data=32'h3FC00000 on three consecutive cycles starting 3 cycles after the first issue, inflight returns to 0, busy drops.
REQ-036 LAT=3, two ops in flight, rst_n pulsed low mid-flight -> outputs zero immediately, no rsp_valid after release, next contention grants port 0.
REQ-037 Port 0 valid alone for 3 transfers, then both valid -> port 1 granted first (pointer reflects last grant = 0).
REQ-038 Idle cycles with neither valid -> add_a=add_b=0, pointer and inflight unchanged, no responses beyond those already in flight.

Source files
------------

// File: rtl/fp32_add_arbiter.sv
// fp32_add_arbiter: round-robin arbiter sharing one pipelined float32 adder between two requesters
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req0_valid/ready/a/b   port 0 request handshake and binary32 operands
//   req1_valid/ready/a/b   port 1 request handshake and binary32 operands
//   rsp0_valid/data        port 0 one-cycle result strobe and sum (zero when idle)
//   rsp1_valid/data        port 1 one-cycle result strobe and sum (zero when idle)
//   add_a, add_b           operands to the shared adder (zero when nothing is granted)
//   add_res                adder result, valid LAT cycles after its operands
//   busy                   any operation in flight
//   inflight               number of operations in flight, 0..LAT
module fp32_add_arbiter #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_res,
    output logic        busy,
    output logic [3:0]  inflight
);
    // last_grant = 1 means port 1 won most recently, so port 0 wins the next contention
    logic           last_grant;
    logic           grant0;
    logic           grant1;
    logic           xfer;
    logic [LAT-1:0] slot_valid;
    logic [LAT-1:0] slot_id;
    logic           out_valid;
    logic           out_id;
    logic [3:0]     count;

    // The adder is fully pipelined, so granting never depends on occupancy;
    // rst_n gates the grant so nothing is offered while reset is held.
    always_comb begin
        grant0 = rst_n && req0_valid && (!req1_valid || last_grant);
        grant1 = rst_n && req1_valid && (!req0_valid || !last_grant);
        xfer   = grant0 || grant1;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign add_a      = grant0 ? req0_a : grant1 ? req1_a : 32'h0;
    assign add_b      = grant0 ? req0_b : grant1 ? req1_b : 32'h0;

    // Oldest issue slot lines up with add_res for the same operation
    assign out_valid  = slot_valid[LAT-1];
    assign out_id     = slot_id[LAT-1];
    assign rsp0_valid = out_valid && !out_id;
    assign rsp1_valid = out_valid && out_id;
    assign rsp0_data  = rsp0_valid ? add_res : 32'h0;
    assign rsp1_data  = rsp1_valid ? add_res : 32'h0;
    assign inflight   = count;
    assign busy       = count != 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            slot_valid <= '0;
            slot_id    <= '0;
            count      <= 4'd0;
        end else begin
            slot_valid <= (slot_valid << 1) | LAT'(xfer);
            slot_id    <= (slot_id << 1) | LAT'(grant1);
            if (xfer)
                last_grant <= grant1;
            count <= count + 4'(xfer) - 4'(out_valid);
        end
    end
endmodule

// File: tb/tb_fp32_add_arbiter.sv
// tb_fp32_add_arbiter: randomized and directed checks of fp32_add_arbiter at LAT=1 and LAT=3
module tb_fp32_add_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        rv0  [2];
    logic        rv1  [2];
    logic [31:0] rd0  [2];
    logic [31:0] rd1  [2];
    logic [31:0] aa   [2];
    logic [31:0] ab   [2];
    logic [31:0] res  [2];
    logic [3:0]  inf  [2];
    logic        bsy  [2];
    logic [31:0] p1;
    logic [31:0] p3 [3];

    typedef struct {
        int          issue;
        logic        port;
        logic [31:0] data;
    } ent_t;

    ent_t         hist[$];
    int           cyc, last, gs, total, bad;
    logic [136:0] e [2];

    always #5 clk = ~clk;

    fp32_add_arbiter #(.LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(rdy0[0]), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(rdy1[0]), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rv0[0]), .rsp0_data(rd0[0]), .rsp1_valid(rv1[0]), .rsp1_data(rd1[0]),
        .add_a(aa[0]), .add_b(ab[0]), .add_res(res[0]), .busy(bsy[0]), .inflight(inf[0])
    );

    fp32_add_arbiter #(.LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(rdy0[1]), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(rdy1[1]), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rv0[1]), .rsp0_data(rd0[1]), .rsp1_valid(rv1[1]), .rsp1_data(rd1[1]),
        .add_a(aa[1]), .add_b(ab[1]), .add_res(res[1]), .busy(bsy[1]), .inflight(inf[1])
    );

    function automatic real f2r(input logic [31:0] x);
        return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'h0});
    endfunction

    // Adder model: real sum for normal operands, a fixed bit mix for specials/denormals
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        if (a[30:23] == 8'hff || b[30:23] == 8'hff || a[30:23] == 8'h0 || b[30:23] == 8'h0)
            return a ^ {b[15:0], b[31:16]};
        r = $realtobits(f2r(a) + f2r(b));
        if (r[62:52] == 11'h0)
            return {r[63], 31'h0};
        return {r[63], 8'(r[62:52] - 11'd896), r[51:29]};
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'h7fc00001;
            1: return 32'hff800000;
            2: return 32'h00000001;
            3: return 32'h80000000;
            default: return $urandom();
        endcase
    endfunction

    always @(posedge clk) begin
        p1    <= fadd(aa[0], ab[0]);
        p3[0] <= fadd(aa[1], ab[1]);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign res[0] = p1;
    assign res[1] = p3[2];

    // fields: ready0 ready1 rsp0_valid rsp1_valid rsp0_data rsp1_data add_a add_b inflight busy
    function automatic logic [136:0] obs(input int k);
        return {rdy0[k], rdy1[k], rv0[k], rv1[k], rd0[k], rd1[k], aa[k], ab[k], inf[k], bsy[k]};
    endfunction

    // Reference: grant by round-robin rule; each issued op responds exactly lat cycles later
    task automatic eval();
        int          lat, n;
        logic        x0, x1;
        logic [31:0] d0, d1;
        gs = !rst_n ? -1 : (req0_valid && req1_valid) ? (last == 0 ? 1 : 0) :
             req0_valid ? 0 : req1_valid ? 1 : -1;
        for (int k = 0; k < 2; k++) begin
            lat = k ? 3 : 1;
            n = 0; x0 = 1'b0; x1 = 1'b0; d0 = 32'h0; d1 = 32'h0;
            foreach (hist[i]) begin
                if (hist[i].issue + lat == cyc) begin
                    if (hist[i].port) begin x1 = 1'b1; d1 = hist[i].data; end
                    else begin x0 = 1'b1; d0 = hist[i].data; end
                end
                if (hist[i].issue < cyc && cyc <= hist[i].issue + lat) n++;
            end
            e[k] = {gs == 0, gs == 1, x0, x1, d0, d1,
                    gs == 0 ? req0_a : gs == 1 ? req1_a : 32'h0,
                    gs == 0 ? req0_b : gs == 1 ? req1_b : 32'h0, 4'(n), n != 0};
        end
    endtask

    task automatic mreset();
        hist.delete();
        last = 1;
    endtask

    task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        #1;
        eval();
    endtask

    task automatic step();
        @(posedge clk);
        if (gs >= 0) begin
            hist.push_back('{issue: cyc, port: gs[0],
                             data: gs == 1 ? fadd(req1_a, req1_b) : fadd(req0_a, req0_b)});
            last = gs;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mreset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rnd_op(), rnd_op(), 1'b1, rnd_op(), rnd_op());
            total += 2;
            if (obs(0) !== e[0]) begin bad++; $display("FAIL reset lat1 i=%0d got=%h want=%h", i, obs(0), e[0]); end
            if (obs(1) !== e[1]) begin bad++; $display("FAIL reset lat3 i=%0d got=%h want=%h", i, obs(1), e[1]); end
            step();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 32'h3f800000, 32'h40000000, 1'b0, 32'h0, 32'h0);
        total += 3;
        if (obs(0) !== e[0]) begin bad++; $display("FAIL single lat1 issue got=%h want=%h", obs(0), e[0]); end
        if (obs(1) !== e[1]) begin bad++; $display("FAIL single lat3 issue got=%h want=%h", obs(1), e[1]); end
        if (rdy0[0] !== 1'b1) begin bad++; $display("FAIL single ready0 got=%b want=1", rdy0[0]); end
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
            total += 2;
            if (obs(0) !== e[0]) begin bad++; $display("FAIL single lat1 i=%0d got=%h want=%h", i, obs(0), e[0]); end
            if (obs(1) !== e[1]) begin bad++; $display("FAIL single lat3 i=%0d got=%h want=%h", i, obs(1), e[1]); end
            if (i == 0) begin
                total++;
                if (!(rv0[0] === 1'b1 && rd0[0] === 32'h40400000 && rv1[0] === 1'b0)) begin
                    bad++; $display("FAIL single rsp0 got v=%b d=%h v1=%b want v=1 d=40400000 v1=0", rv0[0], rd0[0], rv1[0]);
                end
            end
            step();
        end
    endtask

    task automatic test_contention();
        logic [3:0] seq;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive(1'b1, rnd_op(), rnd_op(), 1'b1, rnd_op(), rnd_op());
            else drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
            if (i < 4) seq[i] = rdy1[0];
            total += 2;
            if (obs(0) !== e[0]) begin bad++; $display("FAIL contend lat1 i=%0d got=%h want=%h", i, obs(0), e[0]); end
            if (obs(1) !== e[1]) begin bad++; $display("FAIL contend lat3 i=%0d got=%h want=%h", i, obs(1), e[1]); end
            step();
        end
        total++;
        if (seq !== 4'b1010) begin bad++; $display("FAIL contend grant_order got=%b want=1010", seq); end
    endtask

    task automatic test_back_to_back();
        int mx = 0;
        int hits = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'h0, 32'h0, i < 3, 32'h3f000000, 32'h3f800000);
            total += 2;
            if (obs(0) !== e[0]) begin bad++; $display("FAIL b2b lat1 i=%0d got=%h want=%h", i, obs(0), e[0]); end
            if (obs(1) !== e[1]) begin bad++; $display("FAIL b2b lat3 i=%0d got=%h want=%h", i, obs(1), e[1]); end
            if (int'(inf[1]) > mx) mx = int'(inf[1]);
            if (rv1[1] === 1'b1 && rd1[1] === 32'h3fc00000) hits++;
            step();
        end
        total += 3;
        if (mx != 3) begin bad++; $display("FAIL b2b peak_inflight got=%0d want=3", mx); end
        if (hits != 3) begin bad++; $display("FAIL b2b rsp1_hits got=%0d want=3", hits); end
        if (inf[1] !== 4'd0 || bsy[1] !== 1'b0) begin
            bad++; $display("FAIL b2b drained got inflight=%0d busy=%b want 0 0", inf[1], bsy[1]);
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, rnd_op(), rnd_op(), 1'b0, 32'h0, 32'h0);
            total += 2;
            if (obs(0) !== e[0]) begin bad++; $display("FAIL midrst lat1 issue=%0d got=%h want=%h", i, obs(0), e[0]); end
            if (obs(1) !== e[1]) begin bad++; $display("FAIL midrst lat3 issue=%0d got=%h want=%h", i, obs(1), e[1]); end
            step();
        end
        rst_n = 1'b0;
        mreset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, rnd_op(), rnd_op(), 1'b1, rnd_op(), rnd_op());
            total += 2;
            if (obs(0) !== e[0]) begin bad++; $display("FAIL midrst lat1 held=%0d got=%h want=%h", i, obs(0), e[0]); end
            if (obs(1) !== e[1]) begin bad++; $display("FAIL midrst lat3 held=%0d got=%h want=%h", i, obs(1), e[1]); end
            step();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) drive(1'b1, rnd_op(), rnd_op(), 1'b1, rnd_op(), rnd_op());
            else drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
            total += 2;
            if (obs(0) !== e[0]) begin bad++; $display("FAIL midrst lat1 post=%0d got=%h want=%h", i, obs(0), e[0]); end
            if (obs(1) !== e[1]) begin bad++; $display("FAIL midrst lat3 post=%0d got=%h want=%h", i, obs(1), e[1]); end
            if (i == 0) begin
                total++;
                if (rdy0[1] !== 1'b1 || rdy1[1] !== 1'b0) begin
                    bad++; $display("FAIL midrst first_grant got r0=%b r1=%b want 1 0", rdy0[1], rdy1[1]);
                end
            end
            step();
        end
    endtask

    task automatic test_pointer();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b1, rnd_op(), rnd_op(), 1'b0, 32'h0, 32'h0);
            else drive(1'b1, rnd_op(), rnd_op(), 1'b1, rnd_op(), rnd_op());
            total += 2;
            if (obs(0) !== e[0]) begin bad++; $display("FAIL pointer lat1 i=%0d got=%h want=%h", i, obs(0), e[0]); end
            if (obs(1) !== e[1]) begin bad++; $display("FAIL pointer lat3 i=%0d got=%h want=%h", i, obs(1), e[1]); end
            if (i == 3) begin
                total++;
                if (rdy1[0] !== 1'b1 || rdy0[0] !== 1'b0) begin
                    bad++; $display("FAIL pointer contend got r0=%b r1=%b want 0 1", rdy0[0], rdy1[0]);
                end
            end
            step();
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(1'b0, 32'h0, 32'h0, 1'b1, rnd_op(), rnd_op());
            else if (i < 4) drive(1'b0, rnd_op(), rnd_op(), 1'b0, rnd_op(), rnd_op());
            else drive(1'b1, rnd_op(), rnd_op(), 1'b1, rnd_op(), rnd_op());
            total += 2;
            if (obs(0) !== e[0]) begin bad++; $display("FAIL idle lat1 i=%0d got=%h want=%h", i, obs(0), e[0]); end
            if (obs(1) !== e[1]) begin bad++; $display("FAIL idle lat3 i=%0d got=%h want=%h", i, obs(1), e[1]); end
            if (i > 0 && i < 4) begin
                total++;
                if (aa[1] !== 32'h0 || ab[1] !== 32'h0) begin
                    bad++; $display("FAIL idle add_ops got a=%h b=%h want 0 0", aa[1], ab[1]);
                end
            end
            if (i == 4) begin
                total++;
                if (rdy0[0] !== 1'b1) begin bad++; $display("FAIL idle pointer got r0=%b want 1", rdy0[0]); end
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), $urandom_range(0, 2) != 0, rnd_op(), rnd_op());
            total += 2;
            if (obs(0) !== e[0]) begin bad++; $display("FAIL random lat1 i=%0d got=%h want=%h", i, obs(0), e[0]); end
            if (obs(1) !== e[1]) begin bad++; $display("FAIL random lat3 i=%0d got=%h want=%h", i, obs(1), e[1]); end
            step();
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; gs = -1;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'h0; req0_b = 32'h0; req1_a = 32'h0; req1_b = 32'h0;
        mreset();
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_reset_midflight();
        test_pointer();
        test_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
